// File: rtl/video_sync_gen_if.sv
// Video timing bundle: the pixel enable going into the generator and every
// registered timing output coming back out of it.
//
// pix_ce protocol: there is no valid/ready pair here. pix_ce is a plain
// qualifier sampled on each clk edge. An edge with pix_ce=1 advances the
// raster by one pixel. An edge with pix_ce=0 holds every output, and the
// line_end and frame_start pulses are 0 after that edge.
interface video_sync_gen_if;
  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       active;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_end;
  logic       frame_start;

  // Timing generator side
  modport master (
    input  pix_ce,
    output hsync, vsync, hblank, vblank, active, x, y, line_end, frame_start
  );

  // Pixel consumer side
  modport slave (
    output pix_ce,
    input  hsync, vsync, hblank, vblank, active, x, y, line_end, frame_start
  );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator.
// It contains a horizontal counter and a vertical counter. Every output is
// decoded from the next counter values and registered on the same edge as
// the counters, so each output always describes the current x/y.
// Each total (sum of the four porch/sync/visible terms) must be <= 1024.
module video_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              clr,
  video_sync_gen_if.master  vif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The decode constants are 11 bits wide so that an end bound equal to
  // 1024 can still be represented.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hcount, vcount;
  logic [9:0] h_next, v_next;
  logic [10:0] h_ext, v_ext;

  logic hblank_d, vblank_d, hsync_on, vsync_on, line_end_d, frame_start_d;

  logic hsync_q, vsync_q, hblank_q, vblank_q, active_q;
  logic line_end_q, frame_start_q;

  // Next raster position: x wraps at the end of the line, and y steps only on that wrap
  always_comb begin
    h_next = hcount + 10'd1;
    v_next = vcount;
    if ({1'b0, hcount} == H_LAST) begin
      h_next = '0;
      if ({1'b0, vcount} == V_LAST) v_next = '0;
      else                          v_next = vcount + 10'd1;
    end
  end

  // Decode the next position, so the registered outputs line up with the registered counters
  always_comb begin
    h_ext         = {1'b0, h_next};
    v_ext         = {1'b0, v_next};
    hblank_d      = (h_ext >= H_VIS);
    vblank_d      = (v_ext >= V_VIS);
    hsync_on      = (h_ext >= HS_START) && (h_ext < HS_END);
    vsync_on      = (v_ext >= VS_START) && (v_ext < VS_END);
    line_end_d    = (h_ext == H_LAST);
    frame_start_d = (h_next == 10'd0) && (v_ext == V_VIS);
  end

  // Counters and registered outputs; hold while pix_ce is low, and pulses last one enabled edge only
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hcount        <= '0;
      vcount        <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      active_q      <= 1'b1;
      hsync_q       <= !SYNC_ACTIVE;
      vsync_q       <= !SYNC_ACTIVE;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vif.pix_ce) begin
      hcount        <= h_next;
      vcount        <= v_next;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      active_q      <= !hblank_d && !vblank_d;
      hsync_q       <= hsync_on ? SYNC_ACTIVE : !SYNC_ACTIVE;
      vsync_q       <= vsync_on ? SYNC_ACTIVE : !SYNC_ACTIVE;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end else begin
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign vif.x           = hcount;
  assign vif.y           = vcount;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.hblank      = hblank_q;
  assign vif.vblank      = vblank_q;
  assign vif.active      = active_q;
  assign vif.line_end    = line_end_q;
  assign vif.frame_start = frame_start_q;

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_ACTIVE, default 0, the asserted level of hsync and vsync.
REQ-010 The block SHALL have port clk, input, 1 bit: clock.
REQ-011 The block SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-012 The block SHALL have port pix_ce, input, 1 bit: pixel clock enable; all counting advances only when it is high.
REQ-013 The block SHALL have port hsync, output, 1 bit: horizontal sync at SYNC_ACTIVE polarity.
REQ-014 The block SHALL have port vsync, output, 1 bit: vertical sync at SYNC_ACTIVE polarity.
REQ-015 The block SHALL have port hblank, output, 1 bit: high outside the visible columns.
REQ-016 The block SHALL have port vblank, output, 1 bit: high outside the visible lines; usable as a blink tick.
REQ-017 The block SHALL have port active, output, 1 bit: equal to !hblank && !vblank.
REQ-018 The block SHALL have port x, output, 10 bits: current column (hcount).
REQ-019 The block SHALL have port y, output, 10 bits: current line (vcount).
REQ-020 The block SHALL have port line_end, output, 1 bit: one-cycle pulse on the last pixel of each line.
REQ-021 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse on the first pixel of vblank.

Function
REQ-022 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL equal the sum of the four V parameters; both SHALL be at most 1024.
REQ-023 hcount SHALL increment by 1 on each clk edge with pix_ce=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-024 vcount SHALL increment only on an edge where pix_ce=1 and hcount=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-025 With pix_ce=0 all counters and outputs SHALL hold, and line_end and frame_start SHALL be 0.
REQ-026 All outputs SHALL be registered, SHALL update on the same edge as the counters, and SHALL be consistent with the current x/y (zero relative latency).
REQ-027 hblank SHALL be 1 iff hcount >= H_VISIBLE; vblank SHALL be 1 iff vcount >= V_VISIBLE.
REQ-028 hsync SHALL equal SYNC_ACTIVE iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, and SHALL equal !SYNC_ACTIVE otherwise.
REQ-029 vsync SHALL equal SYNC_ACTIVE iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC; vsync transitions SHALL coincide with hcount=0.
REQ-030 line_end SHALL be 1 iff pix_ce=1 and hcount=H_TOTAL-1.
REQ-031 frame_start SHALL be 1 iff pix_ce=1, hcount=0 and vcount=V_VISIBLE; it SHALL pulse exactly once per frame.
REQ-032 Zero-width porch parameters SHALL be legal, with sync immediately adjacent to the visible region or to the wrap point.

Reset
REQ-033 While clr=1: hcount=0, vcount=0, hblank=0, vblank=0, active=1, hsync=vsync=!SYNC_ACTIVE, line_end=0, frame_start=0.
REQ-034 clr asserted mid-frame SHALL restart timing at (0,0) with no residual pulse; counting SHALL resume on the first pix_ce after clr falls.

Verification
REQ-035 Defaults, pix_ce=1 for 2 frames -> hsync low exactly for x=656..751, 800 clocks per line, vsync low for y=490..491, 420000 clocks per frame.
REQ-036 Defaults -> frame_start exactly once per 420000 clocks at (x=0, y=480); vblank rises on that same edge; line_end every 800 clocks at x=799.
REQ-037 pix_ce toggling 1/0 each cycle -> all frame timings exactly doubled in clk cycles; outputs stable on pix_ce=0 cycles.
REQ-038 Small parameters (4,1,2,1 / 3,1,1,1), SYNC_ACTIVE=1 -> H_TOTAL=8, V_TOTAL=6; hsync high at x=5..6; vsync high at y=4; x wraps 7->0; y wraps 5->0.
REQ-039 clr pulsed at x=300, y=200 -> x=0, y=0, active=1, syncs inactive; the first frame_start occurs 384000 pix_ce cycles after release.
REQ-040 Zero-porch parameters (H_FRONT=0, H_BACK=0) -> hsync asserts at x=H_VISIBLE and deasserts on the wrap to x=0.
